// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues in-order requests to instruction memory, buffers
// up to two returned words with their PCs, and handles branch/jump redirects.
module instruction_fetch #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 imem_req_valid,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] instruction_pc,
  output logic                 instruction_valid,
  input  logic                 instruction_ready
);

  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]           outstanding_q, outstanding_d;
  logic [1:0]           drop_q, drop_d;
  logic [1:0]           count_q, count_d;
  logic                 head_q, head_d;
  logic [WORD_SIZE-1:0] buf_word_q [2];
  logic [WORD_SIZE-1:0] buf_pc_q [2];

  logic [2:0]           credits_used;
  logic                 req_fire;
  logic                 pop;
  logic                 push;
  logic                 tail;
  logic [WORD_SIZE-1:0] resp_pc;

  // Every in-flight request owns a buffer slot, so responses can never overflow.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = reset_n && !redirect_valid && (credits_used < 3'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instruction_valid = (count_q != 2'd0);
  assign instruction       = buf_word_q[head_q];
  assign instruction_pc    = buf_pc_q[head_q];
  assign pop               = instruction_valid && instruction_ready;

  // Kept requests are contiguous and end just below fetch_pc, so the oldest one's PC
  // is fetch_pc minus four per outstanding request.
  assign push    = imem_resp_valid && (drop_q == 2'd0);
  assign tail    = head_q ^ count_q[0];
  assign resp_pc = fetch_pc_q - {{(WORD_SIZE-4){1'b0}}, outstanding_q, 2'b00};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + 2'(req_fire) - 2'(imem_resp_valid);
    drop_d        = drop_q;
    count_d       = count_q;
    head_d        = head_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
    end
    if (imem_resp_valid && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01: begin
        count_d = count_q - 2'd1;
        head_d  = ~head_q;
      end
      2'b11:   head_d = ~head_q;
      default: count_d = count_q;
    endcase

    // A redirect discards everything buffered and every response still in flight.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~WORD_SIZE'(3);
      count_d    = 2'd0;
      head_d     = 1'b0;
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_word_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      head_q        <= head_d;
      if (push) begin
        buf_word_q[tail] <= imem_resp_data;
        buf_pc_q[tail]   <= resp_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a memory model answers requests, a monitor
// pops expected {pc, word} pairs on each decode transfer.
module tb_instruction_fetch;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction, instruction_pc;
  logic        instruction_valid, instruction_ready;

  logic        req2Valid, resp2Valid;
  logic [31:0] req2Addr, inst2, inst2Pc;
  logic        inst2Valid;
  logic [31:0] resp2Data;

  instruction_fetch #(.WORD_SIZE(32), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instruction(instruction),
    .instruction_pc(instruction_pc), .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready)
  );

  // Second instance exercises the address wrap from a high reset PC.
  instruction_fetch #(.WORD_SIZE(32), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(req2Valid), .imem_req_addr(req2Addr),
    .imem_req_ready(1'b1), .imem_resp_valid(resp2Valid),
    .imem_resp_data(resp2Data), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .instruction(inst2),
    .instruction_pc(inst2Pc), .instruction_valid(inst2Valid),
    .instruction_ready(1'b1)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        expQ[$];
  pend_t       pendQ[$];
  logic [31:0] acceptLog[$];
  logic [31:0] wrapLog[$];

  int  cycle = 0;
  int  checkCount = 0;
  int  passCount = 0;
  int  acceptedCount = 0;
  int  transferCount = 0;
  int  maxInFlight = 0;
  bit  trackFlight = 0;
  bit  randomReady = 0;
  bit  randomLat = 0;
  bit  memHold = 0;
  bit  resp2Pending = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input bit rstN, input bit instRdy, input bit redirV,
                               input logic [31:0] redirPc, input bit hold);
    @(negedge clock);
    reset_n           = rstN;
    instruction_ready = instRdy;
    redirect_valid    = redirV;
    redirect_pc       = redirPc;
    memHold           = hold;
  endtask

  task automatic expectRun(input logic [31:0] startPc, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = startPc + 32'(4 * i);
      expQ.push_back('{pc: pc, word: memWord(pc)});
    end
  endtask

  task automatic waitConsumed(input int budget);
    int k;
    k = 0;
    while (expQ.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain_timeout: %0d entries still expected, required 0", expQ.size());
      expQ.delete();
    end
    instruction_ready = 1'b0;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    expQ.delete();
    acceptLog.delete();
  endtask

  // Memory model: junk responses during reset, in-order responses with 1-3 cycle latency.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clock);
      #1;
      cycle++;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      if (!reset_n) begin
        pendQ.delete();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_DEAD;
        imem_req_ready  = 1'b1;
      end else begin
        if (!memHold && pendQ.size() > 0 && pendQ[0].due <= cycle) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = memWord(pendQ[0].addr);
          void'(pendQ.pop_front());
        end
        imem_req_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (reset_n && imem_req_valid && imem_req_ready) begin
        pendQ.push_back('{addr: imem_req_addr,
                          due: cycle + (randomLat ? int'($urandom_range(1, 3)) : 1)});
        acceptLog.push_back(imem_req_addr);
        acceptedCount++;
      end
    end
  end

  // Single-cycle memory for the wrap instance.
  initial begin
    resp2Valid = 1'b0;
    resp2Data  = 32'h0000_0013;
    forever begin
      @(negedge clock);
      #1;
      resp2Valid = resp2Pending && reset_n;
      #1;
      resp2Pending = reset_n && req2Valid;
      if (resp2Pending && wrapLog.size() < 3) wrapLog.push_back(req2Addr);
    end
  end

  // Monitor: each decode transfer pops the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (reset_n && instruction_valid && instruction_ready) begin
        transferCount++;
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_transfer: pc 0x%08h arrived, required no transfer", instruction_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("xfer_pc", instruction_pc, e.pc);
          checkOutput("xfer_word", instruction, e.word);
        end
      end
      if (trackFlight && (acceptedCount - transferCount) > maxInFlight)
        maxInFlight = acceptedCount - transferCount;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n           = 1'b0;
    instruction_ready = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;

    // Reset state, with junk responses arriving during reset
    repeat (3) @(negedge clock);
    #3;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_inst_valid", 32'(instruction_valid), 32'd0);
    checkOutput("rst_inst", instruction, 32'h0);
    checkOutput("rst_inst_pc", instruction_pc, 32'h0);

    // Release with an always-ready memory: latency and address order
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expectRun(32'h0, 6);
    #3;
    checkOutput("rel_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rel_req_addr", imem_req_addr, 32'h0);
    @(negedge clock); #3;
    checkOutput("lat_valid_c1", 32'(instruction_valid), 32'd0);
    @(negedge clock); #3;
    checkOutput("lat_valid_c2", 32'(instruction_valid), 32'd1);
    checkOutput("lat_pc_c2", instruction_pc, 32'h0);
    waitConsumed(60);
    checkOutput("addr_seq0", acceptLog[0], 32'h0);
    checkOutput("addr_seq1", acceptLog[1], 32'h4);
    checkOutput("addr_seq2", acceptLog[2], 32'h8);

    // Decode stalled: buffer fills with 0x0 and 0x4, outputs hold
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (9) @(negedge clock);
    #3;
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall_inst_valid", 32'(instruction_valid), 32'd1);
    checkOutput("stall_pc", instruction_pc, 32'h0);
    checkOutput("stall_word", instruction, memWord(32'h0));
    @(negedge clock); #3;
    checkOutput("stall_pc_hold", instruction_pc, 32'h0);
    checkOutput("stall_count", acceptLog.size(), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expectRun(32'h0, 6);
    waitConsumed(60);

    // Redirect to 0x100 while 0x8 and 0xC are outstanding
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expectRun(32'h0, 2);
    waitConsumed(40);
    memHold = 1'b1;
    repeat (3) @(negedge clock);
    #3;
    checkOutput("pend_count", pendQ.size(), 32'd2);
    checkOutput("pend_addr0", pendQ[0].addr, 32'h8);
    checkOutput("pend_addr1", pendQ[1].addr, 32'hC);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    expectRun(32'h100, 4);
    #3;
    checkOutput("redir_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("redir_addr", imem_req_addr, 32'h100);
    waitConsumed(60);

    // Back-to-back redirects, last one misaligned: fetch resumes at 0x200
    memHold = 1'b1;
    repeat (4) @(negedge clock);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h203, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #3;
    checkOutput("redir_align", imem_req_addr, 32'h200);
    expectRun(32'h200, 4);
    waitConsumed(60);

    // Random ready and latency: strict PC+4 order, at most two in flight
    doReset();
    randomReady = 1'b1;
    randomLat   = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    acceptedCount = 0;
    transferCount = 0;
    maxInFlight   = 0;
    trackFlight   = 1'b1;
    expectRun(32'h0, 250);
    waitConsumed(5000);
    trackFlight = 1'b0;
    checkOutput("rand_transfers", transferCount, 32'd250);
    checkOutput("rand_inflight_le2", 32'(maxInFlight <= 2), 32'd1);

    // Wrap instance address sequence
    checkOutput("wrap_addr0", wrapLog[0], 32'hFFFF_FFF8);
    checkOutput("wrap_addr1", wrapLog[1], 32'hFFFF_FFFC);
    checkOutput("wrap_addr2", wrapLog[2], 32'h0000_0000);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
